// File: rtl/alu_sequencer.sv
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Panel command controller that drives the shared 4-bit ALU through
//             a start/done handshake, including multi-pass shift-and-add multiply.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
  parameter int TIMEOUT = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       SW0,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       SW5,
  input  logic       SW6,
  input  logic       SW7,
  input  logic       enable,
  input  logic [1:0] operation,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_start,
  input  logic [3:0] alu_y,
  input  logic       alu_carry,
  input  logic       alu_done,
  output logic [3:0] rezult,
  output logic       carry,
  output logic       error,
  output logic       busy,
  output logic       done
);

  localparam logic [7:0] c_timeout = TIMEOUT[7:0];
  localparam logic [1:0] c_op_add  = 2'b00;
  localparam logic [1:0] c_op_mul  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_NEXT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     r_state;
  logic       r_en_s1, r_en_s2, r_en_d;
  logic [3:0] r_a;
  logic [3:0] r_mask;
  logic [1:0] r_op;
  logic [3:0] r_acc;
  logic       r_ovf;
  logic [7:0] r_cnt;

  logic [3:0] w_sw_a, w_sw_b;
  logic       w_press;
  logic [1:0] w_bit_idx;
  logic [7:0] w_shift;
  logic [7:0] w_cnt_nxt;

  assign w_sw_a    = {SW3, SW2, SW1, SW0};
  assign w_sw_b    = {SW7, SW6, SW5, SW4};
  assign w_press   = r_en_d & ~r_en_s2;
  assign w_cnt_nxt = r_cnt + 8'd1;
  assign w_shift   = {4'b0000, r_a} << w_bit_idx;

  // Lowest still-pending multiplier bit selects the next partial product.
  always_comb begin
    w_bit_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (r_mask[k]) w_bit_idx = k[1:0];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_en_s1   <= 1'b1;
      r_en_s2   <= 1'b1;
      r_en_d    <= 1'b1;
      r_a       <= 4'd0;
      r_mask    <= 4'd0;
      r_op      <= 2'd0;
      r_acc     <= 4'd0;
      r_ovf     <= 1'b0;
      r_cnt     <= 8'd0;
      alu_a     <= 4'd0;
      alu_b     <= 4'd0;
      alu_op    <= 2'd0;
      alu_start <= 1'b0;
      rezult    <= 4'd0;
      carry     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_en_s1   <= enable;
      r_en_s2   <= r_en_s1;
      r_en_d    <= r_en_s2;
      alu_start <= 1'b0;
      done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_a    <= w_sw_a;
            r_mask <= w_sw_b;
            r_op   <= operation;
            r_acc  <= 4'd0;
            r_ovf  <= 1'b0;
            busy   <= 1'b1;
            if (operation == c_op_mul) begin
              r_state <= S_NEXT;
            end else begin
              alu_a     <= w_sw_a;
              alu_b     <= w_sw_b;
              alu_op    <= operation;
              alu_start <= 1'b1;
              r_state   <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          r_cnt   <= 8'd0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_done) begin
            if (r_op == c_op_mul) begin
              r_acc   <= alu_y;
              r_ovf   <= r_ovf | alu_carry;
              r_state <= S_NEXT;
            end else begin
              rezult  <= alu_y;
              carry   <= alu_carry;
              error   <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end
          end else if (w_cnt_nxt == c_timeout) begin
            error   <= 1'b1;
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= w_cnt_nxt;
          end
        end
        S_NEXT: begin
          if (|r_mask) begin
            alu_a             <= r_acc;
            alu_b             <= w_shift[3:0];
            alu_op            <= c_op_add;
            r_ovf             <= r_ovf | (|w_shift[7:4]);
            r_mask[w_bit_idx] <= 1'b0;
            alu_start         <= 1'b1;
            r_state           <= S_ISSUE;
          end else begin
            rezult  <= r_acc;
            carry   <= r_ovf;
            error   <= 1'b0;
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Self-checking bench for alu_sequencer with a behavioural ALU.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] sw;
  logic       enable;
  logic [1:0] operation;
  logic [3:0] alu_a, alu_b, alu_y, rezult;
  logic [1:0] alu_op;
  logic       alu_start, alu_carry, alu_done;
  logic       carry, error, busy, done;

  int         n_cmp = 0;
  int         n_err = 0;
  int         n_done = 0;
  int         alu_lat = 2;
  bit         alu_en = 1'b1;
  logic [9:0] start_log[$];
  logic [3:0] exp_r = 4'd0;
  logic       exp_c = 1'b0;
  int         start_cyc, done_cyc;

  always #5 clock = ~clock;

  alu_sequencer #(.TIMEOUT(15)) dut (
    .clock(clock), .reset_n(reset_n),
    .SW0(sw[0]), .SW1(sw[1]), .SW2(sw[2]), .SW3(sw[3]),
    .SW4(sw[4]), .SW5(sw[5]), .SW6(sw[6]), .SW7(sw[7]),
    .enable(enable), .operation(operation),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
    .alu_y(alu_y), .alu_carry(alu_carry), .alu_done(alu_done),
    .rezult(rezult), .carry(carry), .error(error), .busy(busy), .done(done)
  );

  // Behavioural ALU: answers alu_lat cycles after a start; carry is the borrow for subtract.
  initial begin
    int         pend;
    logic [4:0] r;
    pend = 0; alu_done = 1'b0; alu_y = 4'd0; alu_carry = 1'b0;
    forever begin
      @(posedge clock); #1;
      alu_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) alu_done = 1'b1;
      end
      if (alu_start === 1'b1) begin
        start_log.push_back({alu_a, alu_b, alu_op});
        case (alu_op)
          2'b00:   r = {1'b0, alu_a} + {1'b0, alu_b};
          2'b01:   r = {1'b0, alu_a} - {1'b0, alu_b};
          2'b10:   r = {1'b0, alu_a & alu_b};
          default: r = {1'b0, alu_a ^ alu_b};
        endcase
        alu_y = r[3:0]; alu_carry = r[4];
        if (alu_en) pend = alu_lat;
      end
    end
  end

  always @(posedge clock) if (done === 1'b1) n_done <= n_done + 1;

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Press, hold for 'hold' cycles, and wait (bounded) for the completion pulse.
  task automatic run_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input int hold);
    bit seen;
    seen = 1'b0; start_cyc = -1; done_cyc = -1;
    start_log.delete();
    sw = {b, a}; operation = op; enable = 1'b0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      @(negedge clock);
      if (cyc == hold) enable = 1'b1;
      if (alu_start === 1'b1 && start_cyc < 0) start_cyc = cyc;
      if (done === 1'b1 && !seen) begin
        seen = 1'b1; done_cyc = cyc;
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
      if (seen && cyc >= hold) break;
    end
    enable = 1'b1;
    chk("done_seen", {31'd0, seen}, 32'd1);
    tick(1);
    chk("busy_after_done", {31'd0, busy}, 32'd0);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  // Reference: plain arithmetic on the latched operands.
  task automatic check_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op, input int d0);
    logic [4:0] s;
    logic [7:0] p, t;
    logic [3:0] acc;
    int         nexp, k;
    case (op)
      2'b00: s = {1'b0, a} + {1'b0, b};
      2'b01: s = {1'b0, a} - {1'b0, b};
      2'b10: s = {1'b0, a & b};
      default: begin
        p = {4'd0, a} * {4'd0, b};
        s = {(p > 8'd15), p[3:0]};
      end
    endcase
    exp_r = s[3:0]; exp_c = s[4];
    nexp = (op == 2'b11) ? $countones(b) : 1;
    chk("rezult", {28'd0, rezult}, {28'd0, exp_r});
    chk("carry", {31'd0, carry}, {31'd0, exp_c});
    chk("error_clear", {31'd0, error}, 32'd0);
    chk("done_pulses", n_done - d0, 32'd1);
    chk("start_count", start_log.size(), nexp);
    if (op != 2'b11) begin
      if (start_log.size() > 0) chk("pass_operands", {22'd0, start_log[0]}, {22'd0, a, b, op});
    end else begin
      acc = 4'd0; k = 0;
      for (int i = 0; i < 4; i++) begin
        if (b[i]) begin
          t = {4'd0, a} << i;
          if (k < start_log.size()) chk("mul_pass", {22'd0, start_log[k]}, {22'd0, acc, t[3:0], 2'b00});
          acc = acc + t[3:0];
          k++;
        end
      end
    end
  endtask

  initial begin
    int d0;
    logic [3:0] ra, rb;
    logic [1:0] rop;
    reset_n = 1'b0; enable = 1'b1; sw = 8'd0; operation = 2'd0;
    tick(2);
    chk("rst_rezult", {28'd0, rezult}, 32'd0);
    chk("rst_flags", {28'd0, carry, error, busy, done}, 32'd0);
    chk("rst_alu", {21'd0, alu_a, alu_b, alu_op, alu_start}, 32'd0);

    // Button already held low across reset release, held for 400 ns.
    sw = 8'h07; enable = 1'b0;
    tick(1);
    reset_n = 1'b1;
    d0 = n_done;
    run_cmd(4'd7, 4'd0, 2'b00, 40);
    tick(2);
    check_cmd(4'd7, 4'd0, 2'b00, d0);

    d0 = n_done; run_cmd(4'd15, 4'd12, 2'b01, 4); tick(2); check_cmd(4'd15, 4'd12, 2'b01, d0);
    d0 = n_done; run_cmd(4'd3, 4'd5, 2'b11, 4);   tick(2); check_cmd(4'd3, 4'd5, 2'b11, d0);
    d0 = n_done; run_cmd(4'd6, 4'd3, 2'b11, 4);   tick(2); check_cmd(4'd6, 4'd3, 2'b11, d0);
    d0 = n_done; run_cmd(4'd9, 4'd0, 2'b11, 4);   tick(2); check_cmd(4'd9, 4'd0, 2'b11, d0);

    // Re-press while busy must be dropped.
    d0 = n_done; start_log.delete();
    sw = {4'd15, 4'd15}; operation = 2'b11; enable = 1'b0;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clock);
      if (cyc == 5 || cyc == 12) enable = 1'b1;
      if (cyc == 7) enable = 1'b0;
      if (cyc == 9) chk("busy_mid", {31'd0, busy}, 32'd1);
    end
    check_cmd(4'd15, 4'd15, 2'b11, d0);

    // ALU never answers: abort after the WAIT budget.
    alu_en = 1'b0;
    d0 = n_done; run_cmd(4'd5, 4'd6, 2'b00, 4); tick(2);
    chk("timeout_error", {31'd0, error}, 32'd1);
    chk("timeout_rezult", {28'd0, rezult}, {28'd0, exp_r});
    chk("timeout_carry", {31'd0, carry}, {31'd0, exp_c});
    chk("timeout_done", n_done - d0, 32'd1);
    chk("timeout_cycles", done_cyc - start_cyc, 32'd16);
    alu_en = 1'b1;
    d0 = n_done; run_cmd(4'd5, 4'd6, 2'b00, 4); tick(2); check_cmd(4'd5, 4'd6, 2'b00, d0);

    // Asynchronous reset in WAIT, then a late ALU answer.
    alu_lat = 8; start_log.delete();
    sw = {4'd9, 4'd10}; operation = 2'b10; enable = 1'b0;
    for (int cyc = 1; cyc <= 20 && start_log.size() == 0; cyc++) tick(1);
    chk("rst_mid_started", start_log.size(), 32'd1);
    enable = 1'b1;
    tick(2); #1;
    reset_n = 1'b0; #1;
    chk("async_rezult", {28'd0, rezult}, 32'd0);
    chk("async_flags", {28'd0, carry, error, busy, done}, 32'd0);
    chk("async_alu", {21'd0, alu_a, alu_b, alu_op, alu_start}, 32'd0);
    tick(1); reset_n = 1'b1;
    d0 = n_done; exp_r = 4'd0; exp_c = 1'b0;
    tick(12);
    chk("late_done_ignored", n_done - d0, 32'd0);
    chk("late_rezult", {28'd0, rezult, busy}, 32'd0);
    alu_lat = 2;
    d0 = n_done; run_cmd(4'd12, 4'd10, 2'b10, 3); tick(2); check_cmd(4'd12, 4'd10, 2'b10, d0);

    for (int n = 0; n < 20; n++) begin
      ra = 4'($urandom_range(0, 15)); rb = 4'($urandom_range(0, 15)); rop = 2'($urandom_range(0, 3));
      d0 = n_done;
      run_cmd(ra, rb, rop, $urandom_range(1, 10));
      tick(2);
      check_cmd(ra, rb, rop, d0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Command controller between the switch/button panel and the shared 4-bit ALU datapath of the CPU.
- Synchronises the active-low `enable` push-button and latches two 4-bit operands from SW0..SW7 plus a 2-bit operation.
- Sequences the ALU through a start/done handshake; multiply (op 11) runs as a multi-pass shift-and-add on the ALU adder.
- Presents a registered 4-bit result with status flags.

Parameters:
- TIMEOUT, 15, max cycles spent in WAIT for `alu_done` before abort (1..255).

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- SW0..SW3  input  1 each  operand A = {SW3,SW2,SW1,SW0}.
- SW4..SW7  input  1 each  operand B = {SW7,SW6,SW5,SW4}.
- enable  input  1  asynchronous push-button, active low; a 1->0 transition issues a command.
- operation  input  2  00 add, 01 subtract, 10 AND, 11 multiply.
- alu_a  output  4  ALU operand A.
- alu_b  output  4  ALU operand B.
- alu_op  output  2  ALU opcode.
- alu_start  output  1  one-cycle ALU request.
- alu_y  input  4  ALU result.
- alu_carry  input  1  ALU carry/borrow.
- alu_done  input  1  ALU result valid.
- rezult  output  4  last completed result, registered.
- carry  output  1  carry flag of last op; for multiply, the overflow flag.
- error  output  1  last command aborted by timeout.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values (async, reset_n=0):
  - rezult=0, carry=0, error=0, busy=0, done=0.
  - alu_start=0, alu_a=0, alu_b=0, alu_op=0.
  - FSM=IDLE; both enable sync flops=1; all internal registers 0.
- Input sampling:
  - `enable` passes through a 2-flop synchroniser.
  - Press = synced value 1 in the previous cycle and 0 in the current cycle.
  - A button held low through reset release yields exactly one press.
- Command acceptance:
  - A press is accepted only in IDLE.
  - Presses in any other state are dropped, not queued.
  - On accept, latch A, B and operation; go to ISSUE.
  - A held-low button never retriggers.
- FSM states: IDLE, ISSUE, WAIT, NEXT, DONE.
- ISSUE (exactly one cycle):
  - alu_start=1; alu_a, alu_b and alu_op driven for the current pass.
  - Go to WAIT.
- WAIT:
  - `alu_done` is sampled only in WAIT and ignored in every other state.
  - On `alu_done` with op 00/01/10: rezult<=alu_y, carry<=alu_carry, error<=0; go to DONE.
  - On `alu_done` with op 11: acc<=alu_y, ovf|=alu_carry; go to NEXT.
  - The cycle counter resets on entry to WAIT.
  - If the counter reaches TIMEOUT without `alu_done`: error<=1, rezult and carry unchanged; go to DONE.
- Multiply (op 11), 4-bit unsigned:
  - acc=0, ovf=0, bit index i=0..3.
  - For each i with B[i]=1: issue alu_a=acc, alu_b=(A<<i)[3:0], alu_op=00.
  - ovf|=1 if any bit of A shifted out above bit 3 is 1 while B[i]=1.
  - NEXT advances i to the next set bit of B: go to ISSUE if one remains; otherwise rezult<=acc, carry<=ovf, go to DONE.
  - B=0: no ALU pass; go straight to DONE from NEXT with rezult=0, carry=0.
  - Number of `alu_start` pulses = popcount(B).
  - A timeout in any pass aborts the whole multiply.
- DONE:
  - done=1 for one cycle; go to IDLE.
  - busy falls in the same cycle as IDLE is entered.
- alu_a, alu_b and alu_op hold their last values between passes.
- Outputs are valid only with alu_start.
- Reset mid-operation aborts immediately; any in-flight ALU result is discarded.

Test Plan:
- ALU model with done 2 cycles after start. SW=0000_0111, op 00, one press -> alu_start once with a=7, b=0, op=00; rezult=7, carry=0; one done pulse; busy high throughout.
- A=15, B=12 (SW3..0=1, SW7,SW6=1), op 01 -> one pass, a=15, b=12, op=01; rezult=3, carry=model carry.
- Op 11: A=3, B=5 -> 2 starts (b=3, then b=12); rezult=15, carry=0. A=6, B=3 -> rezult=2, carry=1. B=0 -> 0 starts, rezult=0, done pulses.
- Second press during busy, and a 400 ns hold -> exactly one command executes; done pulses once.
- ALU never asserts done, TIMEOUT=15 -> after 15 WAIT cycles error=1, rezult unchanged, done pulses, back to IDLE. Next good command -> error=0.
- reset_n low during WAIT -> all outputs 0 asynchronously (before the next edge). Late `alu_done` after release is ignored; a new press works normally.
